// File: rtl/hw_serial_sum_if.sv
// Operand/result bundle for hw_serial_sum: the requester drives start and operands,
// the serial adder returns busy/done and the registered result.
interface hw_serial_sum_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/hw_serial_sum.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB slice first, through a
// ripple full-adder slice and a carry register; result published with a one-cycle done.
module hw_serial_sum #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    hw_serial_sum_if.slave    bus
);
    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("hw_serial_sum: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]   slice_sum_s;
    logic               slice_cmsb_s;
    logic               slice_cout_s;
    logic [WIDTH-1:0]   acc_next_s;

    // Ripple full-adder slice over the low DIGIT bits; keeps the carry into the top bit for ovf.
    always_comb begin
        logic c;
        c           = carry_q;
        slice_sum_s = {DIGIT{1'b0}};
        for (int i = 0; i < DIGIT - 1; i++) begin
            slice_sum_s[i] = a_sh_q[i] ^ b_sh_q[i] ^ c;
            c              = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
        end
        slice_cmsb_s             = c;
        slice_sum_s[DIGIT-1]     = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ c;
        slice_cout_s             = (a_sh_q[DIGIT-1] & b_sh_q[DIGIT-1]) |
                                   (c & (a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1]));
        acc_next_s               = WIDTH'({slice_sum_s, acc_q} >> DIGIT);
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.cin ^ bus.sub;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                acc_d   = acc_next_s;
                carry_d = slice_cout_s;
                // Last slice: its carry-in/carry-out at the MSB give cout and signed overflow.
                if (cnt_q == CW'(NCYC - 1)) begin
                    cnt_d   = {CW{1'b0}};
                    sum_d   = acc_next_s;
                    cout_d  = slice_cout_s;
                    ovf_d   = slice_cout_s ^ slice_cmsb_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
